// File: rtl/fifo_store_non2n.sv
// fifo_store_non2n: single-clock FIFO store whose pointers wrap at FIFO_DEPTH-1 (any depth, not just 2**n).
// Define FIFO_ALMOST_FLAGS_EN to add the almost_full/almost_empty flags and their AF_LEVEL/AE_LEVEL parameters.
module fifo_store_non2n #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 520,
  parameter int PTR_WIDTH  = 10
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  parameter int AF_LEVEL   = FIFO_DEPTH - 4,
  parameter int AE_LEVEL   = 4
`endif
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_WIDTH-1:0]  count,
  output logic                  wr_overflow,
  output logic                  rd_underflow
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  localparam logic [PTR_WIDTH-1:0] LAST_IDX  = PTR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [PTR_WIDTH-1:0] DEPTH_CNT = PTR_WIDTH'(FIFO_DEPTH);
`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [PTR_WIDTH-1:0] AF_CNT    = PTR_WIDTH'(AF_LEVEL);
  localparam logic [PTR_WIDTH-1:0] AE_CNT    = PTR_WIDTH'(AE_LEVEL);
`endif

  logic [DATA_WIDTH-1:0] mem [0:FIFO_DEPTH-1];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH-1:0]  count_nxt;
  logic                  wr_acc;
  logic                  rd_acc;

  // Wrap explicitly at the last entry; a plain binary roll-over would overrun a non-2**n depth.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // Accept decisions use the registered flags, so pointer equality never reaches both sides at once.
  always_comb begin
    wr_acc    = w_en & ~full;
    rd_acc    = r_en & ~empty;
    count_nxt = count;
    if (wr_acc && !rd_acc)
      count_nxt = count + 1'b1;
    else if (rd_acc && !wr_acc)
      count_nxt = count - 1'b1;
  end

  // Storage array: not reset, written only on an accepted write.
  always_ff @(posedge wclk) begin
    if (wr_acc && !wrst)
      mem[wr_ptr] <= wdata;
  end

  // Control and registered outputs; flags derive from count_nxt so they stay coherent with count.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      rdata        <= '0;
      rd_valid     <= 1'b0;
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
`ifdef FIFO_ALMOST_FLAGS_EN
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
`endif
    end else begin
      if (wr_acc)
        wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) begin
        rd_ptr <= ptr_inc(rd_ptr);
        rdata  <= mem[rd_ptr];
      end
      rd_valid     <= rd_acc;
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_CNT);
      empty        <= (count_nxt == '0);
      wr_overflow  <= w_en & full;
      rd_underflow <= r_en & empty;
`ifdef FIFO_ALMOST_FLAGS_EN
      almost_full  <= (count_nxt >= AF_CNT);
      almost_empty <= (count_nxt <= AE_CNT);
`endif
    end
  end

endmodule
